// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
// The E-stage decoder and the hazard control unit use the same opcodes.
package mdu_pkg;

    // Operation codes presented on MDUOp
    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    // Counter width able to hold the longer of the two latencies
    function automatic int mdu_cnt_width(input int mult_cycles, input int div_cycles);
        int max_cycles;
        max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(max_cycles + 1);
    endfunction

    // Counter width for the default latencies (5 and 10)
    localparam int MDU_CNT_W_DEFAULT = mdu_cnt_width(5, 10);

endpackage

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency mult/div into HI/LO, plus mfhi/mflo/mthi/mtlo.
// Results are computed when the op is issued and held pending; the counter
// models the latency and commits the pending values when it reaches zero.
module mdu
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        start,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_out
);

    localparam int CNT_W = mdu_cnt_width(MULT_CYCLES, DIV_CYCLES);

    logic [CNT_W-1:0] r_cnt;
    logic [31:0]      r_hi;
    logic [31:0]      r_lo;
    logic [31:0]      r_hi_nxt;
    logic [31:0]      r_lo_nxt;
    logic             r_skip;     // pending op was a divide by zero: commit nothing

    logic             w_is_md;
    logic             w_accept;
    logic             w_divz;
    logic             w_ovf;
    logic [63:0]      w_prod_s;
    logic [63:0]      w_prod_u;
    logic [31:0]      w_quo_s;
    logic [31:0]      w_rem_s;
    logic [31:0]      w_quo_u;
    logic [31:0]      w_rem_u;

    assign w_is_md = (MDUOp == MDU_MULT) || (MDUOp == MDU_MULTU) ||
                     (MDUOp == MDU_DIV)  || (MDUOp == MDU_DIVU);

    assign busy  = (r_cnt != '0);
    assign start = w_is_md && !busy;

    // Ops are accepted when idle and also in the completion cycle (cnt==1),
    // so a new op can issue on the same edge that commits the previous one
    // and an MTHI/MTLO there overrides the completion write.
    assign w_accept = (r_cnt <= CNT_W'(1));

    assign w_divz = (B == 32'h0);
    assign w_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'h0, A} * {32'h0, B};

    // Division results, guarded so neither zero divisors nor the single
    // signed-overflow case ever reach the behavioural operators
    always_comb begin
        w_quo_s = 32'h0;
        w_rem_s = 32'h0;
        w_quo_u = 32'h0;
        w_rem_u = 32'h0;
        if (!w_divz) begin
            w_quo_u = A / B;
            w_rem_u = A % B;
            if (w_ovf) begin
                w_quo_s = 32'h8000_0000;
                w_rem_s = 32'h0;
            end else begin
                w_quo_s = $signed(A) / $signed(B);
                w_rem_s = $signed(A) % $signed(B);
            end
        end
    end

    // Counter, pending results and architectural HI/LO; later writes in
    // this block take priority over the completion commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_hi     <= 32'h0;
            r_lo     <= 32'h0;
            r_hi_nxt <= 32'h0;
            r_lo_nxt <= 32'h0;
            r_skip   <= 1'b0;
        end else begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - CNT_W'(1);
                if ((r_cnt == CNT_W'(1)) && !r_skip) begin
                    r_hi <= r_hi_nxt;
                    r_lo <= r_lo_nxt;
                end
            end
            if (w_accept) begin
                case (MDUOp)
                    MDU_MULT: begin
                        r_hi_nxt <= w_prod_s[63:32];
                        r_lo_nxt <= w_prod_s[31:0];
                        r_skip   <= 1'b0;
                        r_cnt    <= CNT_W'(MULT_CYCLES);
                    end
                    MDU_MULTU: begin
                        r_hi_nxt <= w_prod_u[63:32];
                        r_lo_nxt <= w_prod_u[31:0];
                        r_skip   <= 1'b0;
                        r_cnt    <= CNT_W'(MULT_CYCLES);
                    end
                    MDU_DIV: begin
                        r_hi_nxt <= w_rem_s;
                        r_lo_nxt <= w_quo_s;
                        r_skip   <= w_divz;
                        r_cnt    <= CNT_W'(DIV_CYCLES);
                    end
                    MDU_DIVU: begin
                        r_hi_nxt <= w_rem_u;
                        r_lo_nxt <= w_quo_u;
                        r_skip   <= w_divz;
                        r_cnt    <= CNT_W'(DIV_CYCLES);
                    end
                    MDU_MTHI: r_hi <= A;
                    MDU_MTLO: r_lo <= A;
                    default: ;
                endcase
            end
        end
    end

    assign HI = r_hi;
    assign LO = r_lo;

    // Read port: old HI/LO are returned even while an op is in flight
    always_comb begin
        MDU_out = 32'h0;
        if (MDUOp == MDU_MFHI) begin
            MDU_out = r_hi;
        end else if (MDUOp == MDU_MFLO) begin
            MDU_out = r_lo;
        end
    end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: a vector table of single ops run from idle,
// followed by hand sequences for back-to-back, busy-time and reset cases.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_out;

    int n_vec = 0;
    int n_bad = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .MDUOp(MDUOp), .A(A), .B(B),
        .start(start), .busy(busy), .HI(HI), .LO(LO), .MDU_out(MDU_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        st;    // expected start in the issue cycle
        logic [31:0] out;   // expected MDU_out in the issue cycle
        int          n;     // expected busy cycles
        logic [31:0] hi;    // expected HI after completion
        logic [31:0] lo;    // expected LO after completion
    } vec_t;

    vec_t vec [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Wait (bounded) until busy drops; returns cycles counted while busy
    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    // Issue one op at posedge+1, hold it for one edge, then idle until done
    task automatic apply(input int idx, input vec_t v);
        int cyc;
        MDUOp = v.op; A = v.a; B = v.b;
        #1;
        chk($sformatf("v%0d start", idx), {31'h0, start}, {31'h0, v.st});
        chk($sformatf("v%0d mdu_out", idx), MDU_out, v.out);
        @(posedge clk); #1;
        MDUOp = MDU_NONE; A = 32'hA5A5_A5A5; B = 32'h5A5A_5A5A;
        wait_idle(cyc);
        chk($sformatf("v%0d busy_cycles", idx), cyc, v.n);
        chk($sformatf("v%0d hi", idx), HI, v.hi);
        chk($sformatf("v%0d lo", idx), LO, v.lo);
        $display("vec %0d op=%0d a=%h b=%h busy=%0d hi=%h lo=%h", idx, v.op, v.a, v.b, cyc, HI, LO);
    endtask

    initial begin
        int cyc;

        vec[0]  = '{4'(MDU_MTLO),  32'h0000_5555, 32'h0,         1'b0, 32'h0,         0,  32'h0,         32'h0000_5555};
        vec[1]  = '{4'(MDU_MULT),  32'hFFFF_FFFE, 32'h3,         1'b1, 32'h0,         5,  32'hFFFF_FFFF, 32'hFFFF_FFFA};
        vec[2]  = '{4'(MDU_MULTU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0,         5,  32'hFFFF_FFFE, 32'h0000_0001};
        vec[3]  = '{4'(MDU_DIVU),  32'hFFFF_FFFF, 32'h2,         1'b1, 32'h0,         10, 32'h0000_0001, 32'h7FFF_FFFF};
        vec[4]  = '{4'(MDU_DIV),   32'hFFFF_FFF9, 32'h2,         1'b1, 32'h0,         10, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
        vec[5]  = '{4'(MDU_MTHI),  32'h0000_1234, 32'h0,         1'b0, 32'h0,         0,  32'h0000_1234, 32'hFFFF_FFFD};
        vec[6]  = '{4'(MDU_DIV),   32'h0000_0064, 32'h0,         1'b1, 32'h0,         10, 32'h0000_1234, 32'hFFFF_FFFD};
        vec[7]  = '{4'(MDU_DIV),   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h0,         10, 32'h0000_0000, 32'h8000_0000};
        vec[8]  = '{4'(MDU_DIVU),  32'h0000_0064, 32'h0,         1'b1, 32'h0,         10, 32'h0000_0000, 32'h8000_0000};
        vec[9]  = '{4'(MDU_DIV),   32'h0000_0007, 32'hFFFF_FFFE, 1'b1, 32'h0,         10, 32'h0000_0001, 32'hFFFF_FFFD};
        vec[10] = '{4'(MDU_MULT),  32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'h0,         5,  32'h3FFF_FFFF, 32'h0000_0001};
        vec[11] = '{4'(MDU_NONE),  32'h1111_1111, 32'h2222_2222, 1'b0, 32'h0,         0,  32'h3FFF_FFFF, 32'h0000_0001};
        vec[12] = '{4'hF,          32'h1111_1111, 32'h2222_2222, 1'b0, 32'h0,         0,  32'h3FFF_FFFF, 32'h0000_0001};
        vec[13] = '{4'(MDU_MFHI),  32'h0,         32'h0,         1'b0, 32'h3FFF_FFFF, 0,  32'h3FFF_FFFF, 32'h0000_0001};
        vec[14] = '{4'(MDU_MFLO),  32'h0,         32'h0,         1'b0, 32'h0000_0001, 0,  32'h3FFF_FFFF, 32'h0000_0001};

        reset = 1'b1; MDUOp = MDU_NONE; A = 32'h0; B = 32'h0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("rst busy", {31'h0, busy}, 32'h0);
        chk("rst hi", HI, 32'h0);
        chk("rst lo", LO, 32'h0);
        chk("rst start_none", {31'h0, start}, 32'h0);
        chk("rst mdu_out_none", MDU_out, 32'h0);
        MDUOp = MDU_MFLO; #1;
        chk("rst mfhi_lo", MDU_out, 32'h0);
        MDUOp = MDU_NONE;
        @(posedge clk); #1;

        for (int i = 0; i < 15; i++) begin
            apply(i, vec[i]);
        end

        // Back-to-back: mult 3*5, multu 16*16 issued in the completion cycle
        MDUOp = MDU_MULT; A = 32'd3; B = 32'd5;
        @(posedge clk); #1;
        MDUOp = MDU_NONE; A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF;
        repeat (4) @(posedge clk);
        #1;
        MDUOp = MDU_MULTU; A = 32'h10; B = 32'h10;
        @(posedge clk); #1;
        MDUOp = MDU_NONE; A = 32'h0; B = 32'h0;
        chk("b2b busy_cont", {31'h0, busy}, 32'h1);
        chk("b2b first_hi", HI, 32'h0);
        chk("b2b first_lo", LO, 32'd15);
        wait_idle(cyc);
        chk("b2b second_cycles", cyc, 5);
        chk("b2b second_lo", LO, 32'h100);
        $display("seq b2b busy=%0d hi=%h lo=%h", cyc, HI, LO);

        // MTHI in the completion cycle of mult 2*3
        MDUOp = MDU_MULT; A = 32'd2; B = 32'd3;
        @(posedge clk); #1;
        MDUOp = MDU_NONE;
        repeat (4) @(posedge clk);
        #1;
        MDUOp = MDU_MTHI; A = 32'h0000_ABCD;
        @(posedge clk); #1;
        MDUOp = MDU_NONE;
        chk("mthi_edge busy", {31'h0, busy}, 32'h0);
        chk("mthi_edge hi", HI, 32'h0000_ABCD);
        chk("mthi_edge lo", LO, 32'd6);
        $display("seq mthi_edge hi=%h lo=%h", HI, LO);

        // Ops presented mid-flight are ignored; MFLO returns the old LO
        MDUOp = MDU_DIVU; A = 32'd100; B = 32'd7;
        @(posedge clk); #1;
        MDUOp = MDU_MTLO; A = 32'h0000_DEAD; #1;
        chk("busy mtlo_start", {31'h0, start}, 32'h0);
        @(posedge clk); #1;
        MDUOp = MDU_MULT; A = 32'd9; B = 32'd9; #1;
        chk("busy mult_start", {31'h0, start}, 32'h0);
        @(posedge clk); #1;
        MDUOp = MDU_MFLO; #1;
        chk("busy mflo_old", MDU_out, 32'd6);
        chk("busy lo_kept", LO, 32'd6);
        @(posedge clk); #1;
        MDUOp = MDU_NONE;
        wait_idle(cyc);
        chk("busy divu_cycles", cyc + 3, 10);
        chk("busy divu_hi", HI, 32'd2);
        chk("busy divu_lo", LO, 32'd14);
        $display("seq busy_ignore hi=%h lo=%h", HI, LO);

        // Asynchronous reset in the middle of a division
        MDUOp = MDU_DIV; A = 32'd50; B = 32'd3;
        @(posedge clk); #1;
        MDUOp = MDU_NONE;
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("areset busy", {31'h0, busy}, 32'h0);
        chk("areset hi", HI, 32'h0);
        chk("areset lo", LO, 32'h0);
        #1 reset = 1'b0;
        @(posedge clk); #1;
        chk("areset stays_idle", {31'h0, busy}, 32'h0);
        $display("seq async_reset busy=%0d hi=%h lo=%h", busy, HI, LO);
        apply(100, '{4'(MDU_MULT), 32'd6, 32'd7, 1'b1, 32'h0, 5, 32'h0, 32'd42});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit for the E stage of the five-stage MIPS pipeline. It executes mult, multu, div and divu as fixed-latency multi-cycle operations into the HI/LO registers and services mfhi, mflo, mthi and mtlo. Its `start` and `busy` outputs feed the hazard control unit. That unit stalls any D-stage multiply/divide-class instruction while an operation is starting or in flight.

## Interface
Parameters:
- `MULT_CYCLES`, 5, busy duration of mult/multu in cycles (≥1)
- `DIV_CYCLES`, 10, busy duration of div/divu in cycles (≥1)

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `MDUOp`  in  4  E-stage operation code (encodings in shared package)
- `A`  in  32  forwarded rs value (E stage, after ALUa forwarding mux)
- `B`  in  32  forwarded rt value (E stage, after ALUb forwarding mux)
- `start`  out  1  combinational: `MDUOp` ∈ {MULT, MULTU, DIV, DIVU} and `busy`=0
- `busy`  out  1  registered: operation in flight
- `HI`  out  32  architectural HI register
- `LO`  out  32  architectural LO register
- `MDU_out`  out  32  HI for MFHI, LO for MFLO, else 32'h0 (combinational)

## Operation
- State: `HI`, `LO`, `cnt` (width to hold max(MULT_CYCLES, DIV_CYCLES)), pending result registers `hi_nxt`/`lo_nxt`.
- `busy` = (`cnt` != 0), taken directly from the register.
- IDLE (`cnt`=0), `start`=1 at edge:
  - MULT: {hi_nxt, lo_nxt} = $signed(A)*$signed(B), 64-bit.
  - MULTU: the same product, unsigned.
  - DIV: lo_nxt = A/B and hi_nxt = A%B, signed. The quotient truncates toward zero and the remainder takes the sign of A.
  - DIVU: the same, unsigned.
  - `cnt` loads MULT_CYCLES or DIV_CYCLES as appropriate.
- BUSY (`cnt`≠0): `cnt` decrements each edge. At the edge where `cnt` goes 1→0, HI←hi_nxt and LO←lo_nxt.
- Divide by zero (B=0, div/divu): the op still takes DIV_CYCLES and busy behaves normally. HI/LO stay unchanged at completion.
- Signed overflow, DIV with A=32'h8000_0000 and B=32'hFFFF_FFFF: LO=32'h8000_0000, HI=0.
- MTHI/MTLO with `busy`=0: HI←A or LO←A at the edge.
- Any MDUOp other than MFHI/MFLO while `busy`=1 is ignored: no state change, `start`=0. The HCU guarantees this does not occur legally. The behaviour is still defined.
- MFHI/MFLO while `busy`=1: `MDU_out` returns the old HI/LO. The HCU must stall these instructions, so this value is never committed.
- NONE and all undefined encodings: no state change, `MDU_out`=0.

## Timing
- Reset values: HI=0, LO=0, `cnt`=0, `busy`=0, hi_nxt/lo_nxt=0. Consequently `start`=0 unless MDUOp requests an op, and `MDU_out`=0 unless MFHI/MFLO.
- Start at edge T: `busy`=1 from T through T+N−1, `busy`=0 from T+N with HI/LO updated at T+N. N is MULT_CYCLES or DIV_CYCLES.
- Operands are captured only at the start edge. Later changes to A/B have no effect.
- Back-to-back: a new start is accepted at edge T+N, the same edge that commits the previous result. The commit uses the old pending values, and the new op loads `cnt` and pending values.
- MTHI at T+N: the MTHI write wins over the completion write for HI. LO still receives lo_nxt.
- `reset` asserted mid-operation: `cnt`, `busy`, HI and LO clear immediately with no clock needed. The in-flight result is discarded.
- `start`, `MDU_out`: zero-latency combinational outputs from MDUOp, `busy`, HI and LO.

## Structure
- Shared package `mdu_pkg`:
  - MDUOp encodings: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8.
  - Helper constant for the `cnt` width.
  - The E-stage decoder and HCU import the same package.
- Single module. No sub-module is required.
- Results are computed with behavioural `*`, `/` and `%` at start. The latency is modelled by the counter, matching the architectural fixed-latency model.

## Test plan
- mult A=32'hFFFF_FFFE (−2), B=3 -> `busy`=1 for exactly 5 cycles, then HI=32'hFFFF_FFFF and LO=32'hFFFF_FFFA; `start`=1 only in the issue cycle.
- divu A=32'hFFFF_FFFF, B=2 -> `busy` for 10 cycles, then LO=32'h7FFF_FFFF and HI=1. Then div A=−7, B=2 -> LO=−3, HI=−1.
- div with B=0 after mthi 32'h1234 -> `busy` for 10 cycles, then HI=32'h1234 and LO unchanged. Also div 32'h8000_0000 / −1 -> LO=32'h8000_0000, HI=0.
- Back-to-back mult then multu issued at the completion edge -> first result committed, second started in the same cycle, `busy` continuous. MTHI at that completion edge -> HI=A and LO=product low word.
- MTLO and MULT presented during busy -> ignored with `start`=0. MFLO during busy -> `MDU_out` equals old LO.
- `reset` pulsed mid-division, not aligned to `clk` -> `busy`, HI and LO read 0 before the next edge, and the next mult behaves normally.
